// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger: FSM states, conversion
// constants and helpers that size counters from the clock/timing parameters.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE
    } state_e;

    localparam int unsigned US_PER_CM = 58;
    localparam logic [15:0] ERR_CODE  = 16'hEEEE;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

    // Clock cycles per microsecond tick, never below one.
    function automatic int unsigned usec_div(input int unsigned clk_hz);
        return (clk_hz < 1_000_000) ? 1 : clk_hz / 1_000_000;
    endfunction

    // Bits needed to hold the values 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_dist_meas_bcd4_counter.sv
// Four-digit cascaded BCD incrementer with synchronous clear; holds at 9999
// instead of rolling over.
module bcd4_counter
    import ultrasonic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q, count_d;
    logic        carry;

    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != BCD_MAX)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ultrasonic_dist_meas.sv
// HC-SR04 style ranger: periodic trigger, echo pulse timing in microseconds,
// conversion to 4-digit BCD centimetres with timeout error reporting.
module ultrasonic_dist_meas
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 125_000_000,
    parameter int unsigned TRIG_US         = 10,
    parameter int unsigned MEAS_PERIOD_MS  = 60,
    parameter int unsigned ECHO_TIMEOUT_MS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] distance_bcd,
    output logic        valid,
    output logic        err
);

    localparam int unsigned USEC_DIV   = usec_div(CLK_FREQ_HZ);
    localparam int unsigned PERIOD_US  = MEAS_PERIOD_MS * 1000;
    localparam int unsigned TIMEOUT_US = ECHO_TIMEOUT_MS * 1000;
    localparam int unsigned PRE_W      = cnt_w(USEC_DIV);
    localparam int unsigned PER_W      = cnt_w(PERIOD_US);
    localparam int unsigned TRG_W      = cnt_w(TRIG_US);
    localparam int unsigned TMO_W      = cnt_w(TIMEOUT_US + 1);
    localparam int unsigned SUB_W      = cnt_w(US_PER_CM);

    state_e state_q, state_d;
    logic   done_err_q, done_err_d;

    logic echo_s1_q, echo_s2_q, echo_s3_q;
    logic echo_rise, echo_fall;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [TRG_W-1:0] trg_cnt_q, trg_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             tick, per_wrap, trig_done, tmo_hit, sub_wrap;

    logic        bcd_clr, bcd_inc;
    logic [15:0] bcd_count;

    logic        trig_q, trig_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] dist_q, dist_d;

    // Two sync stages plus one history stage; edges are decoded from the
    // last two so rise and fall see identical latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_s3_q <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    assign echo_rise = echo_s2_q & ~echo_s3_q;
    assign echo_fall = ~echo_s2_q & echo_s3_q;

    always_comb begin
        tick      = (pre_cnt_q == PRE_W'(USEC_DIV - 1));
        per_wrap  = enable && tick && (per_cnt_q == PER_W'(PERIOD_US - 1));
        trig_done = tick && (trg_cnt_q == TRG_W'(TRIG_US - 1));
        tmo_hit   = tick && (tmo_cnt_q == TMO_W'(TIMEOUT_US - 1));
        sub_wrap  = tick && (sub_cnt_q == SUB_W'(US_PER_CM - 1));
    end

    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

        per_cnt_d = per_cnt_q;
        if (!enable) begin
            per_cnt_d = '0;
        end else if (tick) begin
            per_cnt_d = per_wrap ? '0 : per_cnt_q + 1'b1;
        end

        trg_cnt_d = '0;
        if (state_q == ST_TRIG) begin
            trg_cnt_d = tick ? trg_cnt_q + 1'b1 : trg_cnt_q;
        end

        // Timeout window spans WAIT_RISE and MEASURE; zero everywhere else.
        tmo_cnt_d = '0;
        if ((state_q == ST_WAIT_RISE) || (state_q == ST_MEASURE)) begin
            tmo_cnt_d = tick ? tmo_cnt_q + 1'b1 : tmo_cnt_q;
        end

        sub_cnt_d = sub_cnt_q;
        if (state_q == ST_WAIT_RISE) begin
            sub_cnt_d = '0;
        end else if ((state_q == ST_MEASURE) && tick) begin
            sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            per_cnt_q <= '0;
            trg_cnt_q <= '0;
            tmo_cnt_q <= '0;
            sub_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            per_cnt_q <= per_cnt_d;
            trg_cnt_q <= trg_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            sub_cnt_q <= sub_cnt_d;
        end
    end

    assign bcd_clr = (state_q == ST_WAIT_RISE);
    assign bcd_inc = (state_q == ST_MEASURE) && sub_wrap;

    bcd4_counter u_bcd (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bcd_clr),
        .inc_i   (bcd_inc),
        .count_o (bcd_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_err_q <= done_err_d;
        end
    end

    // An exhausted window in WAIT_RISE beats a late rise, since MEASURE
    // could no longer time out; in MEASURE the falling edge wins.
    always_comb begin
        state_d    = state_q;
        done_err_d = done_err_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (per_wrap) state_d = ST_TRIG;
                end
                ST_TRIG: begin
                    if (trig_done) state_d = ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (tmo_hit) begin
                        state_d    = ST_DONE;
                        done_err_d = 1'b1;
                    end else if (echo_rise) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (echo_fall) begin
                        state_d    = ST_DONE;
                        done_err_d = 1'b0;
                    end else if (tmo_hit) begin
                        state_d    = ST_DONE;
                        done_err_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        trig_d  = (state_d == ST_TRIG);
        valid_d = (state_q == ST_DONE) && enable;
        dist_d  = dist_q;
        err_d   = err_q;
        if (valid_d) begin
            dist_d = done_err_q ? ERR_CODE : bcd_count;
            err_d  = done_err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dist_q  <= '0;
        end else begin
            trig_q  <= trig_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            dist_q  <= dist_d;
        end
    end

    assign trig         = trig_q;
    assign valid        = valid_q;
    assign err          = err_q;
    assign distance_bcd = dist_q;

endmodule

// File: tb/tb_ultrasonic_dist_meas.sv
// Self-checking bench for ultrasonic_dist_meas and its bcd4_counter.
`timescale 1ns/1ps
module tb_ultrasonic_dist_meas;

    localparam int unsigned CYC_PER_US = 2;
    localparam int unsigned TMO_US     = 1000;
    localparam int unsigned TRIG_CYC   = 20;
    localparam int unsigned PERIOD_CYC = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic [15:0] distance_bcd;
    logic        valid;
    logic        err;

    logic        b_clr = 1'b0;
    logic        b_inc = 1'b0;
    logic [15:0] b_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned vcount = 0;
    int unsigned unstable = 0;
    bit          mon_en = 1'b0;
    logic [15:0] pd = '0;
    logic        pe = 1'b0;

    always #250 clk = ~clk;

    ultrasonic_dist_meas #(
        .CLK_FREQ_HZ     (2_000_000),
        .TRIG_US         (10),
        .MEAS_PERIOD_MS  (2),
        .ECHO_TIMEOUT_MS (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .distance_bcd (distance_bcd),
        .valid        (valid),
        .err          (err)
    );

    bcd4_counter u_bcd_unit (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (b_clr),
        .inc_i   (b_inc),
        .count_o (b_cnt)
    );

    always @(posedge clk) begin
        #1;
        if (valid) vcount++;
        if (mon_en && !valid && ((distance_bcd !== pd) || (err !== pe))) unstable++;
        pd = distance_bcd;
        pe = err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int unsigned obs,
                             input int unsigned lo, input int unsigned hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference: distance is whole centimetres of echo width, error when
    // no usable echo ends inside the 1 ms window after the trigger.
    task automatic model(input int unsigned dly, input int unsigned w, input bit stuck,
                         output logic [15:0] ed, output logic ee);
        if (stuck || (w == 0) || (dly + w >= TMO_US)) begin
            ed = 16'hEEEE;
            ee = 1'b1;
        end else begin
            ed = to_bcd(((w / 58) > 9999) ? 9999 : (w / 58));
            ee = 1'b0;
        end
    endtask

    task automatic run_meas(input int unsigned dly, input int unsigned w, input bit stuck,
                            output int unsigned t_first, output int unsigned trig_w,
                            output int unsigned lat, output bit got,
                            output logic [15:0] d, output logic e);
        int unsigned c;
        int unsigned fall_slot;
        t_first = 0;
        while (!trig && (t_first < 6000)) begin
            @(posedge clk); #1; t_first++;
        end
        trig_w = 0;
        while (trig && (trig_w < 200)) begin
            @(posedge clk); #1; trig_w++;
        end
        got = 1'b0; lat = 0; d = 'x; e = 1'bx; c = 0;
        fall_slot = (dly + w) * CYC_PER_US;
        while (!got && (c < 3000)) begin
            @(negedge clk);
            if (!stuck) echo = (w != 0) && (c >= dly * CYC_PER_US) && (c < fall_slot);
            @(posedge clk); #1; c++;
            if (valid) begin
                got = 1'b1; lat = c; d = distance_bcd; e = err;
            end
        end
        if (!stuck && echo) begin
            repeat (fall_slot - c + 1) @(negedge clk);
            echo = 1'b0;
        end
    endtask

    task automatic meas_step(input string name, input int unsigned dly, input int unsigned w,
                             input bit stuck, output int unsigned t_first);
        int unsigned trig_w, lat, vc0;
        bit          got;
        logic [15:0] d, ed;
        logic        e, ee;
        vc0 = vcount;
        model(dly, w, stuck, ed, ee);
        run_meas(dly, w, stuck, t_first, trig_w, lat, got, d, e);
        chk($sformatf("%s trig_width", name), trig_w, TRIG_CYC);
        chk($sformatf("%s valid_seen", name), got, 1);
        chk($sformatf("%s distance", name), d, ed);
        chk($sformatf("%s err", name), e, ee);
        if (ee) chk_range($sformatf("%s timeout_latency", name), lat, 1999, 2003);
        else    chk($sformatf("%s fall_to_valid", name), lat - (dly + w) * CYC_PER_US, 4);
        repeat (3) @(negedge clk);
        chk($sformatf("%s valid_pulses", name), vcount - vc0, 1);
    endtask

    initial begin
        int unsigned t, vc0, m, dly, w, total;
        logic [15:0] hold_d;
        logic        hold_e;

        repeat (3) @(posedge clk);
        #1;
        chk("reset trig", trig, 0);
        chk("reset distance", distance_bcd, 16'h0000);
        chk("reset valid", valid, 0);
        chk("reset err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        b_clr = 1'b1;
        @(posedge clk); #1;
        chk("bcd clear", b_cnt, 16'h0000);
        m = 0;
        for (int i = 0; i < 10040; i++) begin
            @(negedge clk);
            b_clr = 1'b0;
            b_inc = (i < 9990) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (b_inc) m = (m < 9999) ? m + 1 : 9999;
            @(posedge clk); #1;
            chk("bcd count", b_cnt, to_bcd(m));
        end
        @(negedge clk);
        b_inc = 1'b0;
        b_clr = 1'b1;
        @(posedge clk); #1;
        chk("bcd clear_after_sat", b_cnt, 16'h0000);
        @(negedge clk);
        b_clr = 1'b0;

        chk("idle no_valid", vcount, 0);
        mon_en = 1'b1;
        enable = 1'b1;
        meas_step("nominal", 100, 580, 1'b0, t);
        chk_range("first_trigger_after_enable", t, PERIOD_CYC - 3, PERIOD_CYC + 2);
        meas_step("round57", 60, 57, 1'b0, t);
        meas_step("round58", 60, 58, 1'b0, t);
        meas_step("round115", 60, 115, 1'b0, t);
        meas_step("no_echo", 0, 0, 1'b0, t);
        meas_step("after_timeout", 80, 116, 1'b0, t);

        @(negedge clk);
        echo = 1'b1;
        meas_step("stuck_high", 0, 0, 1'b1, t);
        @(negedge clk);
        echo = 1'b0;
        meas_step("before_abort", 50, 300, 1'b0, t);

        vc0 = vcount;
        hold_d = distance_bcd;
        hold_e = err;
        t = 0;
        while (!trig && (t < 6000)) begin @(posedge clk); #1; t++; end
        while (trig && (t < 6200)) begin @(posedge clk); #1; t++; end
        repeat (100) @(negedge clk);
        echo = 1'b1;
        repeat (400) @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort trig_low", trig, 0);
        repeat (200) @(negedge clk);
        echo = 1'b0;
        repeat (2500) @(negedge clk);
        chk("abort no_valid", vcount - vc0, 0);
        chk("abort distance_held", distance_bcd, hold_d);
        chk("abort err_held", err, hold_e);
        enable = 1'b1;
        meas_step("reenable", 60, 300, 1'b0, t);
        chk_range("reenable_first_trigger", t, PERIOD_CYC - 3, PERIOD_CYC + 2);

        t = 0;
        while (!trig && (t < 6000)) begin @(posedge clk); #1; t++; end
        while (trig && (t < 6200)) begin @(posedge clk); #1; t++; end
        repeat (100) @(negedge clk);
        echo = 1'b1;
        repeat (200) @(negedge clk);
        mon_en = 1'b0;
        #100;
        rst = 1'b1;
        #10;
        chk("rst distance", distance_bcd, 16'h0000);
        chk("rst err", err, 0);
        chk("rst trig", trig, 0);
        chk("rst valid", valid, 0);
        echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        meas_step("after_rst", 40, 200, 1'b0, total);
        chk_range("rst_first_trigger", total + 2, PERIOD_CYC - 3, PERIOD_CYC + 2);

        for (int k = 0; k < 5; k++) begin
            dly = $urandom_range(20, 200);
            w   = $urandom_range(1, 1100);
            if ((dly + w >= 995) && (dly + w <= 1005)) w = w - 20;
            meas_step($sformatf("random%0d_d%0d_w%0d", k, dly, w), dly, w, 1'b0, t);
        end

        chk("outputs_stable_between_valid", unstable, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
